// File: rtl/key_schedule_seq_if.sv
// Request/readback bundle for the sequential AES key schedule.
// The master drives requests and the read index; the slave returns status and data.
interface key_schedule_seq_if;
  logic           start;
  logic [1:0]     key_len;
  logic [0:255]   key;
  logic           busy;
  logic           done;
  logic           valid;
  logic           err;
  logic [3:0]     rk_idx;
  logic [0:127]   rk_data;

  modport master (
    output start, key_len, key, rk_idx,
    input  busy, done, valid, err, rk_data
  );

  modport slave (
    input  start, key_len, key, rk_idx,
    output busy, done, valid, err, rk_data
  );
endinterface

// File: rtl/key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one word per clock,
// with a shared SubWord unit and a registered round-key read port.
module key_schedule_seq #(
  parameter int MAX_NK = 8
) (
  input logic            clk,
  input logic            reset,
  key_schedule_seq_if.slave ks
);
  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] addr_t;
  typedef enum logic {IDLE, EXPAND} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH];
  logic [3:0]  nk;
  addr_t       i;
  addr_t       t_last;
  logic [2:0]  m;
  logic [7:0]  rcon;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [3:0]  req_nk;
  logic        req_ok;

  always_comb begin
    req_nk = '0;
    unique case (1'b1)
      (ks.key_len == 2'd0): req_nk = 4'd4;
      (ks.key_len == 2'd1): req_nk = 4'd6;
      (ks.key_len == 2'd2): req_nk = 4'd8;
      default:              req_nk = 4'd0;
    endcase
    req_ok = (req_nk != 4'd0) && (int'(req_nk) <= MAX_NK);
  end

  logic [31:0] prev;
  logic [31:0] back;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] nxt;
  logic        is_rc;
  logic        is_sub;

  always_comb begin
    prev   = mem[i - addr_t'(1)];
    back   = mem[i - addr_t'(nk)];
    is_rc  = (m == 3'd0);
    is_sub = (nk == 4'd8) && (m == 3'd4);
    rot    = is_rc ? {prev[23:0], prev[31:24]} : prev;
    sub    = {sbox(rot[31:24]), sbox(rot[23:16]),
              sbox(rot[15:8]),  sbox(rot[7:0])};
    nxt    = back;
    unique case (1'b1)
      is_rc:   nxt = back ^ sub ^ {rcon, 24'h0};
      is_sub:  nxt = back ^ sub;
      default: nxt = back ^ prev;
    endcase
  end

  addr_t base;
  assign base = addr_t'({ks.rk_idx, 2'b00});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      nk         <= 4'd4;
      i          <= addr_t'(4);
      t_last     <= addr_t'(43);
      m          <= '0;
      rcon       <= 8'h01;
      ks.busy    <= 1'b0;
      ks.done    <= 1'b0;
      ks.valid   <= 1'b0;
      ks.err     <= 1'b0;
      ks.rk_data <= '0;
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else begin
      ks.done <= 1'b0;
      ks.err  <= 1'b0;
      if (ks.rk_idx > (nk + 4'd6)) begin
        ks.rk_data <= '0;
      end else begin
        ks.rk_data <= {mem[base], mem[base + addr_t'(1)],
                       mem[base + addr_t'(2)], mem[base + addr_t'(3)]};
      end
      unique case (state)
        IDLE: begin
          if (ks.start) begin
            if (req_ok) begin
              for (int j = 0; j < MAX_NK; j++) begin
                if (j < int'(req_nk)) mem[j] <= ks.key[32*j +: 32];
              end
              nk       <= req_nk;
              i        <= addr_t'(req_nk);
              t_last   <= addr_t'(4 * (int'(req_nk) + 7) - 1);
              m        <= '0;
              rcon     <= 8'h01;
              ks.busy  <= 1'b1;
              ks.valid <= 1'b0;
              state    <= EXPAND;
            end else begin
              ks.err <= 1'b1;
            end
          end
        end
        EXPAND: begin
          mem[i] <= nxt;
          i      <= i + addr_t'(1);
          m      <= (m == 3'(nk - 4'd1)) ? 3'd0 : m + 3'd1;
          if (is_rc) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (i == t_last) begin
            state    <= IDLE;
            ks.busy  <= 1'b0;
            ks.done  <= 1'b1;
            ks.valid <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_schedule_seq.sv
// Randomized bench for key_schedule_seq against a FIPS-197 style
// table-driven expansion model, plus the published key vectors.
module tb_key_schedule_seq;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  key_schedule_seq_if ifa ();
  key_schedule_seq_if ifb ();

  key_schedule_seq #(.MAX_NK(8)) dut_a (.clk(clk), .reset(reset), .ks(ifa));
  key_schedule_seq #(.MAX_NK(4)) dut_b (.clk(clk), .reset(reset), .ks(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [127:0] sbt [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic [7:0]  rcon_tab [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08,
                                 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [31:0] wr [60];

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [127:0] row;
    row = sbt[x[7:4]];
    return row[8*(15 - int'(x[3:0])) +: 8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction

  task automatic model(input int nk, input logic [0:255] k);
    logic [31:0] t;
    for (int j = 0; j < 60; j++) wr[j] = '0;
    for (int j = 0; j < nk; j++) wr[j] = k[32*j +: 32];
    for (int j = nk; j < 4 * (nk + 7); j++) begin
      t = wr[j-1];
      if (j % nk == 0)
        t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[j/nk], 24'h0};
      else if (nk == 8 && j % 8 == 4)
        t = subw(t);
      wr[j] = wr[j-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r, input int nk);
    if (r > nk + 6) return '0;
    return {wr[4*r], wr[4*r+1], wr[4*r+2], wr[4*r+3]};
  endfunction

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [1:0] len, input logic [0:255] k,
                       input int inj, output int lat);
    logic [0:255] alt;
    alt = {$urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom};
    ifa.key = k;
    ifa.key_len = len;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    check("accept_busy", 128'(ifa.busy), 128'd1);
    check("accept_valid", 128'(ifa.valid), 128'd0);
    lat = 0;
    while (!ifa.done && lat < 100) begin
      if (lat == inj) begin
        ifa.start = 1'b1;
        ifa.key = alt;
        ifa.key_len = 2'd0;
      end
      tick();
      lat++;
      ifa.start = 1'b0;
    end
    check("done_valid", 128'(ifa.valid), 128'd1);
    check("done_busy", 128'(ifa.busy), 128'd0);
  endtask

  task automatic rd_a(input int r, output logic [127:0] d);
    ifa.rk_idx = 4'(r);
    tick();
    d = ifa.rk_data;
  endtask

  task automatic check_all(input int nk);
    logic [127:0] d;
    for (int r = 0; r < 16; r++) begin
      rd_a(r, d);
      check($sformatf("rk nk=%0d r=%0d", nk, r), d, exp_rk(r, nk));
    end
  endtask

  logic [0:255] k128;
  logic [0:255] k192;
  logic [0:255] k256;
  logic [0:255] kr;
  logic [127:0] d;
  int           lat;
  int           len;

  initial begin
    n_chk = 0;
    n_fail = 0;
    k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    ifa.start = 1'b0; ifa.key_len = '0; ifa.key = '0; ifa.rk_idx = '0;
    ifb.start = 1'b0; ifb.key_len = '0; ifb.key = '0; ifb.rk_idx = '0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_busy", 128'(ifa.busy), 128'd0);
    check("rst_done", 128'(ifa.done), 128'd0);
    check("rst_valid", 128'(ifa.valid), 128'd0);
    check("rst_err", 128'(ifa.err), 128'd0);
    check("rst_rk", ifa.rk_data, 128'd0);
    reset = 1'b0;
    tick();
    rd_a(0, d);
    check("post_rst_rk0", d, 128'd0);

    run_a(2'd0, k128, -1, lat);
    check("lat128", 128'(lat), 128'd40);
    tick();
    check("done_pulse", 128'(ifa.done), 128'd0);
    rd_a(10, d);
    check("fips128_r10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_a(0, d);
    check("fips128_r0", d, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    model(4, k128);
    check_all(4);

    run_a(2'd1, k192, -1, lat);
    check("lat192", 128'(lat), 128'd46);
    rd_a(12, d);
    check("fips192_r12", d, 128'he98ba06f448c773c8ecc720401002202);
    rd_a(13, d);
    check("fips192_r13", d, 128'd0);

    run_a(2'd2, k256, 17, lat);
    check("lat256", 128'(lat), 128'd52);
    rd_a(14, d);
    check("fips256_r14", d, 128'hfe4890d1e6188d0b046df344706c631e);
    model(8, k256);
    check_all(8);

    ifa.key_len = 2'd3;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    check("err_pulse", 128'(ifa.err), 128'd1);
    check("err_busy", 128'(ifa.busy), 128'd0);
    check("err_valid", 128'(ifa.valid), 128'd1);
    tick();
    check("err_once", 128'(ifa.err), 128'd0);
    rd_a(14, d);
    check("err_store", d, 128'hfe4890d1e6188d0b046df344706c631e);

    ifa.key = k128;
    ifa.key_len = 2'd0;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    repeat (19) tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 128'(ifa.busy), 128'd0);
    check("arst_valid", 128'(ifa.valid), 128'd0);
    check("arst_rk", ifa.rk_data, 128'd0);
    tick();
    reset = 1'b0;
    tick();
    check("arst_hold_valid", 128'(ifa.valid), 128'd0);
    run_a(2'd1, k192, -1, lat);
    check("lat192_after_rst", 128'(lat), 128'd46);
    rd_a(12, d);
    check("rst192_r12", d, 128'he98ba06f448c773c8ecc720401002202);

    for (int p = 0; p < 4; p++) begin
      len = int'($urandom_range(0, 2));
      kr = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
      run_a(2'(len), kr, -1, lat);
      check("lat_rand_a", 128'(lat), 128'(4 * (4 + 2*len + 7) - (4 + 2*len)));
      len = int'($urandom_range(0, 2));
      kr = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
      run_a(2'(len), kr, -1, lat);
      check("lat_rand_b2b", 128'(lat), 128'(4 * (4 + 2*len + 7) - (4 + 2*len)));
      model(4 + 2*len, kr);
      check_all(4 + 2*len);
    end

    ifb.key_len = 2'd1;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    check("b_err192", 128'(ifb.err), 128'd1);
    check("b_busy192", 128'(ifb.busy), 128'd0);
    check("b_valid192", 128'(ifb.valid), 128'd0);
    ifb.key = k128;
    ifb.key_len = 2'd0;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    check("b_busy128", 128'(ifb.busy), 128'd1);
    lat = 0;
    while (!ifb.done && lat < 100) begin
      tick();
      lat++;
    end
    check("b_lat128", 128'(lat), 128'd40);
    ifb.rk_idx = 4'd10;
    tick();
    check("b_fips128_r10", ifb.rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    ifb.rk_idx = 4'd11;
    tick();
    check("b_r11_zero", ifb.rk_data, 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
